timer_scheduler: RTL and testbench

- Shares a single down-counting interval timer among N_REQ requesters.
- Each requester asks for a delay measured in tick strobes. A round-robin arbiter picks one requester, and the block loads that requester's delay and counts it down.
- When the count ends, the block pulses that requester's done line and returns to arbitration.
- Sits between the prescaler (source of tick) and the client FSMs that need timed waits.

---
 rtl/timer_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/timer_scheduler.sv | 165 ++++++++++++++++
 tb/tb_timer_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared types and constants for the timer scheduler.
//   - state_e        : scheduler FSM states (idle / counting / done pulse)
//   - N_REQ_DEFAULT  : default number of requesters
//   - CNT_W_DEFAULT  : default counter width
//   - ptr_w()        : width of a requester index / round-robin pointer
package timer_sched_pkg;

    localparam int unsigned N_REQ_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Searches req from bit ptr upward, wrapping modulo N_REQ, and reports the
// first set bit.
// Ports:
//   req   - request vector
//   ptr   - highest-priority position for this search
//   grant - one-hot of the winner (zero when no request)
//   idx   - binary index of the winner
//   valid - at least one request present
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT,
    parameter int unsigned PTR_W = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [PTR_W-1:0] scan_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        valid    = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = PTR_W'((32'(ptr) + i) % N_REQ);
            if (!valid && req[scan_idx]) begin
                valid           = 1'b1;
                idx             = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: one down-counting interval timer shared by N_REQ requesters.
// A round-robin pick selects a requester, its delay is loaded and counted down
// on tick strobes, then a one-cycle done pulse is returned to that requester.
// Optional feature macro: TIMER_SCHED_ABORT_EN (adds the abort input).
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high reset
//   tick      - count-enable strobe from the prescaler
//   abort     - (TIMER_SCHED_ABORT_EN only) drop the running job, no done
//   req       - per-requester request level, held until done
//   delay     - per-requester delay, requester i at [i*CNT_W +: CNT_W]
//   grant     - one-hot owner of the timer
//   done      - one-cycle completion pulse
//   busy      - high while counting and during the done cycle
//   count_val - current counter value
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
`ifdef TIMER_SCHED_ABORT_EN
    input  logic                     abort,
`endif
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   delay,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [CNT_W-1:0]         count_val
);

    localparam int unsigned PTR_W = ptr_w(N_REQ);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx_q, idx_d;

    logic [N_REQ-1:0] arb_grant;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_valid;
    logic             abort_job;
    logic             count_zero;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] delay_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_delay
        assign delay_arr[g] = delay[g*CNT_W +: CNT_W];
    end

`ifdef TIMER_SCHED_ABORT_EN
    assign abort_job = abort;
`else
    assign abort_job = 1'b0;
`endif

    assign count_zero = (count_q == '0);
    // Pointer moves past the job just finished so the next search starts after it.
    assign ptr_next   = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (arb_valid) state_d = StCount;
            StCount: begin
                // Abort outranks an expiring count so no done is ever issued.
                if (abort_job)       state_d = StIdle;
                else if (count_zero) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and job bookkeeping.
    always_comb begin
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (arb_valid) begin
                    grant_d = arb_grant;
                    count_d = delay_arr[arb_idx];
                    busy_d  = 1'b1;
                    idx_d   = arb_idx;
                end
            end
            StCount: begin
                if (abort_job) begin
                    grant_d = '0;
                    count_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                end else if (count_zero) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    busy_d  = 1'b1;
                    ptr_d   = ptr_next;
                end else if (tick) begin
                    count_d = count_q - 1'b1;
                end
            end
            StDone: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign count_val = count_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed self-checking bench for timer_scheduler.
// Expected done pulses are queued as jobs are requested and popped when the
// DUT pulses done. Abort stimulus is built only with TIMER_SCHED_ABORT_EN.
module tb_timer_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           tick;
    logic [N-1:0]   req;
    logic [N*W-1:0] delay;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count_val;
`ifdef TIMER_SCHED_ABORT_EN
    logic           abort;
`endif

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_done_q [$];
    logic [N-1:0] fair_order [5];

    always #5 clk = ~clk;

    timer_scheduler #(
        .N_REQ (N),
        .CNT_W (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
`ifdef TIMER_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .req       (req),
        .delay     (delay),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count_val (count_val)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and score any done pulse.
    task automatic step();
        logic [N-1:0] exp;
        @(posedge clk);
        #1;
        if (done !== '0) begin
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp = exp_done_q.pop_front();
                check("sb_done", 32'(done), 32'(exp));
            end
        end
        check("grant_done_overlap", 32'(grant & done), 32'd0);
    endtask

    task automatic set_delay(input int i, input logic [W-1:0] v);
        delay[i*W +: W] = v;
    endtask

    task automatic wait_grant(input string tag, input logic [N-1:0] exp, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (grant === '0 && n < budget);
        check(tag, 32'(grant), 32'(exp));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (done === '0 && n < budget);
        check(tag, 32'(done !== '0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fair_order[0] = 4'b0001;
        fair_order[1] = 4'b0010;
        fair_order[2] = 4'b0100;
        fair_order[3] = 4'b1000;
        fair_order[4] = 4'b0001;
        reset = 1'b1;
        tick  = 1'b0;
        req   = '0;
        delay = '0;
`ifdef TIMER_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        step();
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count_val), 32'd0);
        reset = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Single request, delay 3, tick every cycle.
        req = 4'b0001;
        set_delay(0, 16'd3);
        tick = 1'b1;
        step();
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_load", 32'(count_val), 32'd3);
        exp_done_q.push_back(4'b0001);
        for (int k = 2; k >= 0; k--) begin
            step();
            check("t1_count", 32'(count_val), 32'(k));
            check("t1_hold_grant", 32'(grant), 32'b0001);
        end
        step();
        check("t1_done", 32'(done), 32'b0001);
        check("t1_done_busy", 32'(busy), 32'd1);
        req = '0;
        step();
        check("t1_busy_drop", 32'(busy), 32'd0);
        check("t1_done_drop", 32'(done), 32'd0);

        // Zero delay completes without any tick.
        req = 4'b0100;
        set_delay(2, 16'd0);
        tick = 1'b0;
        step();
        check("t2_grant", 32'(grant), 32'b0100);
        exp_done_q.push_back(4'b0100);
        step();
        check("t2_done", 32'(done), 32'b0100);
        req = '0;
        step();
        check("t2_idle", 32'(busy), 32'd0);

        // Gated tick: count holds between strobes.
        req = 4'b0001;
        set_delay(0, 16'd2);
        step();
        check("t3_grant", 32'(grant), 32'b0001);
        exp_done_q.push_back(4'b0001);
        step();
        check("t3_hold_a", 32'(count_val), 32'd2);
        step();
        check("t3_hold_b", 32'(count_val), 32'd2);
        tick = 1'b1;
        step();
        check("t3_tick1", 32'(count_val), 32'd1);
        tick = 1'b0;
        step();
        check("t3_hold_c", 32'(count_val), 32'd1);
        step();
        check("t3_hold_d", 32'(count_val), 32'd1);
        tick = 1'b1;
        step();
        check("t3_tick2", 32'(count_val), 32'd0);
        check("t3_no_done_yet", 32'(done), 32'd0);
        tick = 1'b0;
        step();
        check("t3_done", 32'(done), 32'b0001);
        req = '0;
        step();

        // Fairness with all four requesting continuously.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_delay(i, 16'd1);
        tick = 1'b1;
        req  = 4'b1111;
        for (int j = 0; j < 5; j++) exp_done_q.push_back(fair_order[j]);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin
                step();
                check("fair_gap", 32'(grant), 32'd0);
            end
            wait_grant($sformatf("fair_grant%0d", j), fair_order[j], 4);
            wait_done($sformatf("fair_done%0d", j), 4);
            if (j == 4) req = '0;
        end
        step();

        // Delay changes during COUNT are ignored.
        req = 4'b0001;
        set_delay(0, 16'd5);
        wait_grant("t5_grant", 4'b0001, 4);
        check("t5_load", 32'(count_val), 32'd5);
        set_delay(0, 16'd1);
        exp_done_q.push_back(4'b0001);
        for (int k = 4; k >= 0; k--) begin
            step();
            check("t5_count", 32'(count_val), 32'(k));
        end
        step();
        check("t5_done", 32'(done), 32'b0001);
        req = '0;
        step();

        // Reset mid-job abandons it with no done pulse.
        req = 4'b0010;
        set_delay(1, 16'd10);
        wait_grant("t6_grant", 4'b0010, 4);
        repeat (7) step();
        check("t6_count3", 32'(count_val), 32'd3);
        reset = 1'b1;
        step();
        check("t6_grant", 32'(grant), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_count", 32'(count_val), 32'd0);
        reset = 1'b0;
        req   = '0;
        repeat (3) begin
            step();
            check("t6_quiet", 32'(done), 32'd0);
        end

`ifdef TIMER_SCHED_ABORT_EN
        // Abort at count 6: no done, next search starts after the aborted job.
        req = 4'b0001;
        set_delay(0, 16'd10);
        set_delay(1, 16'd1);
        wait_grant("ab_grant", 4'b0001, 4);
        repeat (4) step();
        check("ab_count6", 32'(count_val), 32'd6);
        abort = 1'b1;
        step();
        check("ab_grant0", 32'(grant), 32'd0);
        check("ab_count0", 32'(count_val), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_nodone", 32'(done), 32'd0);
        abort = 1'b0;
        req   = 4'b0011;
        wait_grant("ab_next", 4'b0010, 4);
        exp_done_q.push_back(4'b0010);
        wait_done("ab_next_done", 4);
        req = '0;
        step();
`endif

        check("sb_empty", 32'(exp_done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
